// File: rtl/conv3x3_stream_engine_pkg.sv
// Shared definitions for the 3x3 streaming filter: mode encodings,
// blur kernel weights and the normalisation constants.
package conv3x3_stream_engine_pkg;

    typedef enum logic [1:0] {
        MODE_IDENT  = 2'b00,
        MODE_BLUR   = 2'b01,
        MODE_EDGE   = 2'b10,
        MODE_BRIGHT = 2'b11
    } mode_e;

    // Gaussian 1-2-1 x 1-2-1 kernel, total weight 16.
    localparam int BLUR_SHIFT = 4;
    localparam int BLUR_ROUND = 8;
    // Edge kernel: centre weight against the eight neighbours at -1.
    localparam int EDGE_CTR_K = 8;

    function automatic int blur_k(input int i, input int j);
        return ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
    endfunction

endpackage

// File: rtl/conv3x3_stream_engine_line_buffer_2row.sv
// Two image-row delay lines indexed by column. Reading and writing the same
// column in one cycle returns the old contents, so tap1 is the pixel one row
// above the incoming one and tap2 two rows above.
module line_buffer_2row #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 400,
    parameter int AW     = 9
) (
    input  logic              clk_40,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2
);

    logic [DATA_W-1:0] row1 [DEPTH];
    logic [DATA_W-1:0] row2 [DEPTH];

    assign tap1 = row1[addr];
    assign tap2 = row2[addr];

    // Push the new pixel into row1 and cascade the displaced one into row2.
    always_ff @(posedge clk_40) begin
        if (en) begin
            row1[addr] <= din;
            row2[addr] <= row1[addr];
        end
    end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 filter (identity / blur / edge / brightness) over raster
// pixels. Two-stage pipe: stage 1 forms window sums, stage 2 normalises and
// clamps. A single global stall holds everything while output is blocked.
module conv3x3_stream_engine #(
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3,
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 300,
    parameter int ADDR_W = 18
) (
    input  logic                   clk_40,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [CH_W:0]          bright_offset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sof,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CH*CH_W-1:0] out_data,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   frame_done
);
    import conv3x3_stream_engine_pkg::*;

    localparam int PIX_W  = NUM_CH * CH_W;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int SUM_W  = CH_W + 4;
    localparam int EDGE_W = CH_W + 5;
    localparam int MAXV   = (1 << CH_W) - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);

    logic adv, accept;
    logic [COL_W-1:0] col, pos_c;
    logic [ROW_W-1:0] row, pos_r;
    logic pos_first, win_ok;
    mode_e mode_q;
    logic [CH_W:0] off_q;

    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;
    assign accept   = in_valid && in_ready;

    // in_sof resynchronises the accepted pixel to (0,0)
    assign pos_c     = in_sof ? '0 : col;
    assign pos_r     = in_sof ? '0 : row;
    assign pos_first = (pos_c == '0) && (pos_r == '0);
    assign win_ok    = (pos_r >= ROW_W'(2)) && (pos_c >= COL_W'(2));

    // Raster position counters and per-frame latch of mode/offset
    always_ff @(posedge clk_40) begin
        if (!reset) begin
            col    <= '0;
            row    <= '0;
            mode_q <= MODE_IDENT;
            off_q  <= '0;
        end else if (accept) begin
            if (pos_c == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (pos_r == ROW_W'(IMG_H - 1)) ? '0 : pos_r + ROW_W'(1);
            end else begin
                col <= pos_c + COL_W'(1);
                row <= pos_r;
            end
            if (pos_first) begin
                mode_q <= mode_e'(mode);
                off_q  <= bright_offset;
            end
        end
    end

    logic [PIX_W-1:0] tap1, tap2;

    line_buffer_2row #(.DATA_W(PIX_W), .DEPTH(IMG_W), .AW(COL_W)) u_lbuf (
        .clk_40 (clk_40),
        .en     (accept),
        .addr   (pos_c),
        .din    (in_data),
        .tap1   (tap1),
        .tap2   (tap2)
    );

    // Window columns, index 0 = oldest row (top)
    logic [2:0][PIX_W-1:0] wc0, wc1, wcn;
    logic [2:0][2:0][PIX_W-1:0] win;   // [row][col]

    assign wcn = {in_data, tap1, tap2};

    // Shift the two previous window columns on each accepted pixel
    always_ff @(posedge clk_40) begin
        if (accept) begin
            wc0 <= wc1;
            wc1 <= wcn;
        end
    end

    // Assemble the full window with the incoming column on the right
    always_comb begin
        win = '0;
        for (int i = 0; i < 3; i++) begin
            win[i][0] = wc0[i];
            win[i][1] = wc1[i];
            win[i][2] = wcn[i];
        end
    end

    logic [ADDR_W-1:0] addr_d, s1_addr;
    logic s1_valid;
    mode_e s1_mode;
    logic [CH_W:0] s1_off;
    logic [NUM_CH-1:0][SUM_W-1:0]  blur_d, s1_blur;
    logic [NUM_CH-1:0][EDGE_W-1:0] edge_d, s1_edge;
    logic [NUM_CH-1:0][CH_W-1:0]   ctr_d, s1_ctr;
    logic [PIX_W-1:0] out_d;

    // Window centre is one row up and one column left of the accepted pixel
    assign addr_d = ADDR_W'(pos_r) * ADDR_W'(IMG_W) + ADDR_W'(pos_c) - ADDR_W'(IMG_W + 1);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam int LSB = PIX_W - (ch + 1) * CH_W;   // channel 0 at MSB
        localparam logic signed [EDGE_W-1:0] EMAX = EDGE_W'(MAXV);
        localparam logic signed [CH_W+1:0]   BMAX = (CH_W + 2)'(MAXV);
        int blur_acc, edge_acc;
        logic [SUM_W-1:0] rnd;
        logic signed [EDGE_W-1:0] e_v;
        logic signed [CH_W+1:0] b_v;
        logic [CH_W-1:0] res;

        // Stage-1 kernel sums for this channel
        always_comb begin
            blur_acc = 0;
            edge_acc = 0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    blur_acc = blur_acc + blur_k(i, j) * int'(win[i][j][LSB +: CH_W]);
                    if (i == 1 && j == 1)
                        edge_acc = edge_acc + EDGE_CTR_K * int'(win[i][j][LSB +: CH_W]);
                    else
                        edge_acc = edge_acc - int'(win[i][j][LSB +: CH_W]);
                end
            end
        end

        assign blur_d[ch] = SUM_W'(blur_acc);
        assign edge_d[ch] = EDGE_W'(edge_acc);
        assign ctr_d[ch]  = win[1][1][LSB +: CH_W];

        // Stage-2 normalise / clamp for this channel
        always_comb begin
            rnd = s1_blur[ch] + SUM_W'(BLUR_ROUND);
            e_v = $signed(s1_edge[ch]);
            b_v = $signed({2'b00, s1_ctr[ch]}) + $signed({s1_off[CH_W], s1_off});
            res = s1_ctr[ch];
            case (s1_mode)
                MODE_BLUR:   res = rnd[SUM_W-1:BLUR_SHIFT];
                MODE_EDGE:   res = e_v[EDGE_W-1] ? '0 : (e_v > EMAX) ? CH_W'(MAXV) : e_v[CH_W-1:0];
                MODE_BRIGHT: res = b_v[CH_W+1] ? '0 : (b_v > BMAX) ? CH_W'(MAXV) : b_v[CH_W-1:0];
                default:     res = s1_ctr[ch];
            endcase
        end

        assign out_d[LSB +: CH_W] = res;
    end

    // Stage 1: capture window sums and target address for interior centres
    always_ff @(posedge clk_40) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept && win_ok;
            if (accept) begin
                s1_addr <= addr_d;
                s1_mode <= mode_q;
                s1_off  <= off_q;
                s1_blur <= blur_d;
                s1_edge <= edge_d;
                s1_ctr  <= ctr_d;
            end
        end
    end

    // Stage 2: output register, held while downstream stalls
    always_ff @(posedge clk_40) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= out_d;
                out_addr <= s1_addr;
            end
        end
    end

    assign frame_done = out_valid && out_ready && (out_addr == LAST_ADDR);

endmodule
